// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham line engine feeding a 1-bit frame buffer.
// Takes two endpoints on draw_start and presents one pixel per cycle on
// DrawX/DrawY with draw_data as the write strobe. It advances only when the
// frame buffer accepts the pixel, and ends with a one-cycle draw_done.
//
// Optional feature: define LINE_CLIP_EN to blank pixels outside
// (XMAX, YMAX). A blanked pixel is stepped past without waiting on fb_ready.
//
// Handshake: a pixel is offered while draw_data=1 (state PLOT). It is taken
// on any rising edge where fb_ready=1. While fb_ready=0 the coordinate,
// error term and strobe all hold. fb_ready has no effect outside PLOT.
//
// state_dbg mirrors the FSM state (0 IDLE, 1 SETUP, 2 PLOT, 3 DONE).
module line_rasterizer #(
  parameter int XMAX = 639,
  parameter int YMAX = 479
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       draw_start,
  input  logic [9:0] x0,
  input  logic [9:0] y0,
  input  logic [9:0] x1,
  input  logic [9:0] y1,
  input  logic       fb_ready,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       draw_data,
  output logic       draw_done,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PLOT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched far endpoint. The near endpoint lives in DrawX/DrawY from the
  // start, so it needs no separate copy.
  logic [9:0] x1_r, y1_r;

  // Bresenham terms. dx >= 0 and dy <= 0, so err = dx+dy fits in 12 bits
  // and e2 = 2*err fits in 13 bits.
  logic signed [10:0] dx, dy;
  logic               sx_neg, sy_neg;
  logic signed [11:0] err;

  logic        [9:0]  adx, ady;
  logic signed [12:0] e2, dx_e, dy_e;
  logic signed [11:0] err_step;
  logic               visible, accept, at_end, step_x, step_y;

  // Setup arithmetic, the pixel accept decision and the Bresenham step.
  always_comb begin
    adx = (x1_r >= DrawX) ? (x1_r - DrawX) : (DrawX - x1_r);
    ady = (y1_r >= DrawY) ? (y1_r - DrawY) : (DrawY - y1_r);

`ifdef LINE_CLIP_EN
    visible = (32'(DrawX) <= XMAX) && (32'(DrawY) <= YMAX);
`else
    visible = 1'b1;
`endif

    // A blanked pixel is never written, so it never has to wait for the buffer.
    accept = fb_ready || !visible;
    at_end = (DrawX == x1_r) && (DrawY == y1_r);

    e2     = $signed({err, 1'b0});
    dx_e   = {{2{dx[10]}}, dx};
    dy_e   = {{2{dy[10]}}, dy};
    step_x = (e2 >= dy_e);
    step_y = (e2 <= dx_e);

    // Both corrections use the e2 from before the update.
    err_step = err;
    if (step_x) err_step = err_step + {dy[10], dy};
    if (step_y) err_step = err_step + {dx[10], dx};
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (draw_start) state_nxt = SETUP;
      SETUP:   state_nxt = PLOT;
      PLOT:    if (accept && at_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the endpoints, set up the deltas, step on each accept.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x1_r   <= '0;
      y1_r   <= '0;
      DrawX  <= '0;
      DrawY  <= '0;
      dx     <= '0;
      dy     <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      err    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (draw_start) begin
            x1_r  <= x1;
            y1_r  <= y1;
            DrawX <= x0;
            DrawY <= y0;
          end
        end
        SETUP: begin
          dx     <= $signed({1'b0, adx});
          dy     <= -$signed({1'b0, ady});
          sx_neg <= (x1_r < DrawX);
          sy_neg <= (y1_r < DrawY);
          err    <= $signed({2'b00, adx}) - $signed({2'b00, ady});
        end
        PLOT: begin
          if (accept && !at_end) begin
            if (step_x) DrawX <= sx_neg ? (DrawX - 10'd1) : (DrawX + 10'd1);
            if (step_y) DrawY <= sy_neg ? (DrawY - 10'd1) : (DrawY + 10'd1);
            err <= err_step;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; there is no path from the inputs.
  always_comb begin
    draw_data = (state == PLOT) && visible;
    draw_done = (state == DONE);
    busy      = (state != IDLE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// tb_line_rasterizer: directed and randomized line checks against an
// integer Bresenham model of the expected pixel sequence.
module tb_line_rasterizer;

  localparam int XMAX = 639;
  localparam int YMAX = 479;

  logic       Clk, Reset, draw_start, fb_ready;
  logic [9:0] x0, y0, x1, y1;
  logic [9:0] DrawX, DrawY;
  logic       draw_data, draw_done, busy;
  logic [1:0] state_dbg;

  logic [19:0] exp_q[$];   // expected pixels, {x, y}
  int n_tests = 0;
  int n_fail  = 0;

  line_rasterizer #(.XMAX(XMAX), .YMAX(YMAX)) dut (
    .Clk(Clk), .Reset(Reset), .draw_start(draw_start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .fb_ready(fb_ready),
    .DrawX(DrawX), .DrawY(DrawY), .draw_data(draw_data),
    .draw_done(draw_done), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic pix_visible(input logic [19:0] p);
`ifdef LINE_CLIP_EN
    return (int'(p[19:10]) <= XMAX) && (int'(p[9:0]) <= YMAX);
`else
    return (p != 20'hFFFFF) || 1'b1;
`endif
  endfunction

  // Fill exp_q with every pixel from (ax0,ay0) to (ax1,ay1), inclusive.
  task automatic build_expected(input int ax0, input int ay0, input int ax1, input int ay1);
    int x, y, ddx, ddy, sx, sy, e, e2;
    exp_q.delete();
    x   = ax0;
    y   = ay0;
    ddx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    ddy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax1 >= ax0) ? 1 : -1;
    sy  = (ay1 >= ay0) ? 1 : -1;
    e   = ddx + ddy;
    forever begin
      exp_q.push_back({10'(x), 10'(y)});
      if (x == ax1 && y == ay1) break;
      e2 = 2 * e;
      if (e2 >= ddy) begin e += ddy; x += sx; end
      if (e2 <= ddx) begin e += ddx; y += sy; end
    end
  endtask

  // ---------------- driver ----------------
  // mode 0: fb_ready always 1; 1: random fb_ready; 2: fb_ready low on
  // cycles 3..5 plus a stray draw_start on cycle 4; 3: fb_ready only for
  // visible pixels. exp_done < 0 skips the fixed done-cycle check.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int mode, input int exp_done);
    int cyc, stalls, n;
    logic [19:0] p;
    logic vis, acc;
    build_expected(ax0, ay0, ax1, ay1);
    n = exp_q.size();
    @(negedge Clk);
    x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
    draw_start = 1'b1;
    fb_ready   = 1'b1;
    @(negedge Clk);
    cyc = 1;
    draw_start = 1'b0;
    // Endpoints wander after the latch; the line must not notice.
    x0 = 10'($urandom_range(0, 1023)); y0 = 10'($urandom_range(0, 1023));
    x1 = 10'($urandom_range(0, 1023)); y1 = 10'($urandom_range(0, 1023));
    check("setup_busy", int'(busy), 1);
    check("setup_data", int'(draw_data), 0);
    check("setup_done", int'(draw_done), 0);
    stalls = 0;
    while (exp_q.size() > 0 && cyc < 5000) begin
      @(negedge Clk);
      cyc++;
      draw_start = 1'b0;
      p   = exp_q[0];
      vis = pix_visible(p);
      check("pix_x", int'(DrawX), int'(p[19:10]));
      check("pix_y", int'(DrawY), int'(p[9:0]));
      check("pix_data", int'(draw_data), int'(vis));
      check("pix_busy", int'(busy), 1);
      check("pix_done", int'(draw_done), 0);
      case (mode)
        1:       fb_ready = ($urandom_range(0, 3) != 0);
        2:       fb_ready = !(cyc >= 3 && cyc <= 5);
        3:       fb_ready = vis;
        default: fb_ready = 1'b1;
      endcase
      if (mode == 2 && cyc == 4) begin
        draw_start = 1'b1;
        x0 = 10'd50; y0 = 10'd60; x1 = 10'd70; y1 = 10'd80;
      end
      acc = fb_ready || !vis;
      if (acc) void'(exp_q.pop_front());
      else     stalls++;
    end
    check("pixels_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge Clk);
    cyc++;
    draw_start = 1'b0;
    fb_ready   = 1'b1;
    check("done_pulse", int'(draw_done), 1);
    check("done_busy", int'(busy), 1);
    check("done_data", int'(draw_data), 0);
    check("done_cycle", cyc, n + 2 + stalls);
    if (exp_done >= 0) check("done_cycle_plan", cyc, exp_done);
    @(negedge Clk);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(draw_done), 0);
    check("idle_data", int'(draw_data), 0);
  endtask

  task automatic rand_coord(output int v);
    v = int'($urandom_range(0, 1023));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ax0, ay0, ax1, ay1;
    Reset = 1'b1; draw_start = 1'b0; fb_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (2) @(negedge Clk);
    check("rst_x", int'(DrawX), 0);
    check("rst_y", int'(DrawY), 0);
    check("rst_data", int'(draw_data), 0);
    check("rst_done", int'(draw_done), 0);
    check("rst_busy", int'(busy), 0);
    Reset = 1'b0;

    // Directed lines from the plan.
    run_line(0, 0, 3, 0, 0, 6);
    run_line(5, 5, 5, 5, 0, 3);
    run_line(10, 10, 8, 4, 0, 9);
    run_line(0, 0, 3, 3, 2, 9);
    run_line(637, 0, 641, 0, 3, 7);

    // Reset in the middle of a long line.
    @(negedge Clk);
    x0 = 10'd0; y0 = 10'd0; x1 = 10'd100; y1 = 10'd0;
    draw_start = 1'b1; fb_ready = 1'b1;
    @(negedge Clk);
    draw_start = 1'b0;
    repeat (19) @(negedge Clk);
    check("pre_rst_x", int'(DrawX), 18);
    Reset = 1'b1;
    #1;
    check("mid_rst_x", int'(DrawX), 0);
    check("mid_rst_y", int'(DrawY), 0);
    check("mid_rst_data", int'(draw_data), 0);
    check("mid_rst_done", int'(draw_done), 0);
    check("mid_rst_busy", int'(busy), 0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("post_rst_done", int'(draw_done), 0);
      check("post_rst_busy", int'(busy), 0);
    end
    run_line(0, 0, 2, 1, 0, 5);

    // Randomized lines, mostly short, with random backpressure.
    for (int i = 0; i < 40; i++) begin
      rand_coord(ax0); rand_coord(ay0);
      if ($urandom_range(0, 9) < 7) begin
        ax1 = ax0 + int'($urandom_range(0, 40)) - 20;
        ay1 = ay0 + int'($urandom_range(0, 40)) - 20;
        if (ax1 < 0) ax1 = 0;
        if (ax1 > 1023) ax1 = 1023;
        if (ay1 < 0) ay1 = 0;
        if (ay1 > 1023) ay1 = 1023;
      end else begin
        rand_coord(ax1); rand_coord(ay1);
      end
      run_line(ax0, ay0, ax1, ay1, int'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
